// File: rtl/du_dmem_burst_tx.sv
// Data-memory burst dump over UART. An address and a word count arrive as
// LSB-first bytes on the Rx FIFO. Each word is read from memory and sent out
// LSB-first on the Tx side, optionally followed by an XOR checksum byte.
// An all-ones address ends the session.
module du_dmem_burst_tx #(
   parameter int unsigned NB_DATA      = 32,
   parameter int unsigned NB_UART_DATA = 8,
   parameter int unsigned NB_COUNT     = 16,
   parameter int unsigned DMEM_LAT     = 1
) (
   input  logic                    clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_cksum_en,
   input  logic                    i_rx_done,
   input  logic [NB_UART_DATA-1:0] i_rx_data,
   input  logic                    i_tx_done,
   input  logic [NB_DATA-1:0]      i_dmem_data,
   output logic                    o_done,
   output logic                    o_rd,
   output logic                    o_wr,
   output logic                    o_tx_start,
   output logic [NB_UART_DATA-1:0] o_wdata,
   output logic                    o_dmem_rd,
   output logic [1:0]              o_dmem_rsize,
   output logic [NB_DATA-1:0]      o_dmem_raddr
);

   localparam int unsigned ADDR_BYTES = NB_DATA / NB_UART_DATA;
   localparam int unsigned CNT_BYTES  = NB_COUNT / NB_UART_DATA;
   localparam int unsigned ADDR_STEP  = NB_DATA / 8;

   typedef enum logic [6:0] {
      StIdle   = 7'b0000001,
      StRxAddr = 7'b0000010,
      StRxCnt  = 7'b0000100,
      StRead   = 7'b0001000,
      StSend   = 7'b0010000,
      StCksum  = 7'b0100000,
      StDrain  = 7'b1000000
   } state_e;

   state_e                  state_q, state_d;
   logic [NB_DATA-1:0]      addr_q, addr_d;
   logic [NB_COUNT-1:0]     cnt_q, cnt_d;
   logic [NB_DATA-1:0]      word_q, word_d;
   logic [NB_UART_DATA-1:0] cksum_q, cksum_d;
   logic [7:0]              bcnt_q, bcnt_d;
   logic [2:0]              lat_q, lat_d;
   logic                    busy_q, busy_d;
   logic                    cksum_en_q, cksum_en_d;
   logic                    done_q, done_d;

   logic                    issue;
   logic [NB_UART_DATA-1:0] tx_byte;
   logic [NB_DATA-1:0]      addr_shift;
   logic [NB_COUNT-1:0]     cnt_shift;

   // Bytes are shifted in at the MSB end so the first byte ends up as the LSB.
   assign addr_shift = {i_rx_data, addr_q[NB_DATA-1:NB_UART_DATA]};
   assign cnt_shift  = {i_rx_data, cnt_q[NB_COUNT-1:NB_UART_DATA]};

   // Next-state logic, datapath updates and Rx/memory/Tx strobes.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      word_d     = word_q;
      cksum_d    = cksum_q;
      bcnt_d     = bcnt_q;
      lat_d      = lat_q;
      cksum_en_d = cksum_en_q;
      done_d     = 1'b0;
      issue      = 1'b0;
      tx_byte    = '0;
      o_rd       = 1'b0;
      o_dmem_rd  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               state_d = StRxAddr;
               bcnt_d  = '0;
            end
         end

         StRxAddr: begin
            if (i_rx_done) begin
               o_rd   = 1'b1;
               addr_d = addr_shift;
               if (bcnt_q == 8'(ADDR_BYTES - 1)) begin
                  bcnt_d = '0;
                  if (&addr_shift) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     state_d = StRxCnt;
                  end
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end
         end

         StRxCnt: begin
            if (i_rx_done) begin
               o_rd  = 1'b1;
               cnt_d = cnt_shift;
               if (bcnt_q == 8'(CNT_BYTES - 1)) begin
                  bcnt_d = '0;
                  if (cnt_shift == '0) begin
                     state_d = StRxAddr;
                  end else begin
                     cksum_d    = '0;
                     cksum_en_d = i_cksum_en;
                     lat_d      = '0;
                     state_d    = StRead;
                  end
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end
         end

         StRead: begin
            o_dmem_rd = 1'b1;
            if (lat_q == 3'(DMEM_LAT - 1)) begin
               word_d  = i_dmem_data;
               lat_d   = '0;
               bcnt_d  = '0;
               state_d = StSend;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end

         StSend: begin
            if (!busy_q) begin
               issue   = 1'b1;
               tx_byte = word_q[NB_UART_DATA-1:0];
               word_d  = word_q >> NB_UART_DATA;
               cksum_d = cksum_q ^ word_q[NB_UART_DATA-1:0];
               if (bcnt_q == 8'(ADDR_BYTES - 1)) begin
                  bcnt_d = '0;
                  addr_d = addr_q + NB_DATA'(ADDR_STEP);
                  cnt_d  = cnt_q - NB_COUNT'(1);
                  if (cnt_q != NB_COUNT'(1)) begin
                     lat_d   = '0;
                     state_d = StRead;
                  end else if (cksum_en_q) begin
                     state_d = StCksum;
                  end else begin
                     state_d = StDrain;
                  end
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end
         end

         StCksum: begin
            if (!busy_q) begin
               issue   = 1'b1;
               tx_byte = cksum_q;
               state_d = StDrain;
            end
         end

         StDrain: begin
            if (!busy_q) begin
               bcnt_d  = '0;
               state_d = StRxAddr;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Tx pacing: a new issue wins over a simultaneous tx_done.
   always_comb begin
      busy_d = (busy_q & ~i_tx_done) | issue;
   end

   // Output shaping: idle values are all zero.
   always_comb begin
      o_done       = done_q;
      o_wr         = issue;
      o_tx_start   = issue;
      o_wdata      = issue ? tx_byte : '0;
      o_dmem_rsize = o_dmem_rd ? 2'b11 : 2'b00;
      o_dmem_raddr = o_dmem_rd ? addr_q : '0;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         cnt_q      <= '0;
         word_q     <= '0;
         cksum_q    <= '0;
         bcnt_q     <= '0;
         lat_q      <= '0;
         busy_q     <= 1'b0;
         cksum_en_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         cksum_q    <= cksum_d;
         bcnt_q     <= bcnt_d;
         lat_q      <= lat_d;
         busy_q     <= busy_d;
         cksum_en_q <= cksum_en_d;
         done_q     <= done_d;
      end
   end

endmodule
